// File: rtl/cdc_pkg.sv
// Shared definitions for the pulse-bridge arbiter: FSM encoding and default sizes.
package cdc_pkg;

    // Arbiter FSM encoding, kept as plain 2-bit constants for legacy compatibility
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_ACT  = 2'd2;
    localparam logic [1:0] WAIT_IDLE = 2'd3;

    // Default watchdog limit, in source-clock cycles spent in a wait state
    localparam int unsigned TO_CYC_DEFAULT = 1024;

    // Width of the launched-transfer counter
    localparam int unsigned XFER_CNT_W = 16;

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping mod NREQ.
module cdc_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] cand;

    // Scan ptr+1 .. ptr+NREQ; the requester just served is looked at last
    always_comb begin
        any    = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any    = 1'b1;
                gnt_id = cand;
            end
        end
    end

endmodule

// File: rtl/cdc_pulse_arb.sv
// Source-side arbiter sharing one pulse/data CDC bridge between NREQ requesters.
module cdc_pulse_arb
    import cdc_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned DW     = 8,
    parameter  int unsigned TO_CYC = TO_CYC_DEFAULT,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic [NREQ-1:0]       req_rdy,
    output logic [IDW+DW-1:0]     br_din,
    output logic                  br_vld,
    input  logic                  br_active,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  timeout_err,
    input  logic                  timeout_clr,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    localparam int unsigned    WD_W   = $clog2(TO_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC - 1);

    logic [1:0]            state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [NREQ-1:0]       rdy_q, rdy_d;
    logic                  vld_q, vld_d;
    logic [IDW+DW-1:0]     din_q, din_d;
    logic [IDW-1:0]        gid_q, gid_d;
    logic                  err_q, err_d;
    logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

    logic                  pick_any;
    logic [IDW-1:0]        pick_id;
    logic [DW-1:0]         pick_data;
    logic                  wd_hit;

    cdc_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_vld),
        .ptr    (rr_ptr_q),
        .any    (pick_any),
        .gnt_id (pick_id)
    );

    // Payload mux for the picked requester
    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state: grant only from IDLE with a quiet bridge; watchdog runs in both wait states
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        rdy_d    = '0;
        vld_d    = 1'b0;
        din_d    = din_q;
        gid_d    = gid_q;
        cnt_d    = cnt_q;
        wd_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any && !br_active) begin
                    rdy_d[pick_id] = 1'b1;
                    vld_d          = 1'b1;
                    din_d          = {pick_id, pick_data};
                    gid_d          = pick_id;
                    rr_ptr_d       = pick_id;
                    cnt_d          = cnt_q + 1'b1;
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                wd_hit = (wd_q == WD_MAX);
                if (br_active) begin
                    wd_d    = '0;
                    state_d = WAIT_IDLE;
                end else if (!wd_hit) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                wd_hit = (wd_q == WD_MAX);
                if (!br_active) begin
                    wd_d    = '0;
                    state_d = IDLE;
                end else if (!wd_hit) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A watchdog hit outranks a simultaneous clear
        if (wd_hit) begin
            err_d = 1'b1;
        end else if (timeout_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDW'(NREQ - 1);
            wd_q     <= '0;
            rdy_q    <= '0;
            vld_q    <= 1'b0;
            din_q    <= '0;
            gid_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            din_q    <= din_d;
            gid_q    <= gid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_rdy     = rdy_q;
    assign br_vld      = vld_q;
    assign br_din      = din_q;
    assign grant_id    = gid_q;
    assign timeout_err = err_q;
    assign xfer_cnt    = cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// Self-checking bench for cdc_pulse_arb with a simple bridge model and a transfer-level reference.
`timescale 1ns/1ps
module tb_cdc_pulse_arb;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int TO_CYC = 16;
    localparam int IDW    = 2;
    localparam int BW     = IDW + DW;

    logic              s_clk = 1'b0;
    logic              s_rst = 1'b1;
    logic [NREQ-1:0]   req_vld = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_rdy;
    logic [BW-1:0]     br_din;
    logic              br_vld;
    logic              br_active;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              timeout_err;
    logic              timeout_clr = 1'b0;
    logic [15:0]       xfer_cnt;

    int checks   = 0;
    int failures = 0;

    cdc_pulse_arb #(
        .NREQ   (NREQ),
        .DW     (DW),
        .TO_CYC (TO_CYC)
    ) dut (
        .s_clk       (s_clk),
        .s_rst       (s_rst),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .br_din      (br_din),
        .br_vld      (br_vld),
        .br_active   (br_active),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .timeout_clr (timeout_clr),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bridge model: active rises 2 cycles after s_vld and falls at 6, unless stuck or forced
    logic bridge_act = 1'b0;
    logic force_act  = 1'b0;
    bit   stuck      = 1'b0;
    bit   running    = 1'b0;
    int   tick       = 0;
    assign br_active = bridge_act | force_act;

    always @(negedge s_clk) begin
        if (br_vld) begin
            running = 1'b1;
            tick    = 0;
        end else if (running) begin
            tick++;
        end
        bridge_act = running && tick >= 2 && (stuck || tick < 6);
        if (running && tick >= 6 && !stuck) running = 1'b0;
    end

    // Reference: one outstanding transfer, tracked by the edges at which it launched and saw active rise
    bit              m_out    = 1'b0;
    int              m_launch = 0;
    int              m_rose   = -1;
    int              m_last   = NREQ - 1;
    int              cyc      = 0;
    logic [NREQ-1:0] m_rdy    = '0;
    logic            m_vld    = 1'b0;
    logic [BW-1:0]   m_din    = '0;
    logic [IDW-1:0]  m_gid    = '0;
    logic            m_err    = 1'b0;
    logic [15:0]     m_cnt    = '0;

    always @(posedge s_clk) begin
        bit waiting;
        bit set_err;
        int entry;
        int g;
        cyc++;
        if (s_rst) begin
            m_out  = 1'b0;
            m_rose = -1;
            m_last = NREQ - 1;
            m_rdy  = '0;
            m_vld  = 1'b0;
            m_din  = '0;
            m_gid  = '0;
            m_err  = 1'b0;
            m_cnt  = '0;
        end else begin
            waiting = m_out && (cyc > m_launch + 1);
            entry   = (m_rose < 0) ? m_launch + 1 : m_rose;
            set_err = waiting && (cyc - entry >= TO_CYC);
            m_rdy   = '0;
            m_vld   = 1'b0;
            if (!m_out) begin
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (req_vld[c]) begin
                        g = c;
                        break;
                    end
                end
                if (g >= 0 && !br_active) begin
                    m_out    = 1'b1;
                    m_launch = cyc;
                    m_rose   = -1;
                    m_last   = g;
                    m_rdy[g] = 1'b1;
                    m_vld    = 1'b1;
                    m_gid    = g[IDW-1:0];
                    m_din    = {g[IDW-1:0], req_data[g*DW +: DW]};
                    m_cnt    = m_cnt + 16'd1;
                end
            end else if (m_rose < 0) begin
                if (cyc > m_launch + 1 && br_active) m_rose = cyc;
            end else if (!br_active) begin
                m_out = 1'b0;
            end
            if (set_err) m_err = 1'b1;
            else if (timeout_clr) m_err = 1'b0;
        end
    end

    // Every-cycle comparison against the reference
    always @(negedge s_clk) begin
        chk("req_rdy", req_rdy, m_rdy);
        chk("br_vld", br_vld, m_vld);
        chk("br_din", br_din, m_din);
        chk("grant_id", grant_id, m_gid);
        chk("busy", busy, m_out);
        chk("timeout_err", timeout_err, m_err);
        chk("xfer_cnt", xfer_cnt, m_cnt);
        if (br_vld) chk("no_overlap", br_active, 0);
    end

    bit auto_clr = 1'b1;

    task automatic step();
        @(negedge s_clk);
        if (auto_clr) req_vld = req_vld & ~req_rdy;
    endtask

    task automatic wait_vld(input int max_cyc, output int k);
        k = 0;
        while (!br_vld && k < max_cyc) begin
            step();
            k++;
        end
        chk("vld_seen", br_vld, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (busy && k < max_cyc) begin
            step();
            k++;
        end
        chk("idle_seen", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, req_rdy, 0);
        chk({tag, "_vld"}, br_vld, 0);
        chk({tag, "_din"}, br_din, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_err"}, timeout_err, 0);
        chk({tag, "_cnt"}, xfer_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int k;
        // Reset state
        s_rst = 1'b1;
        step();
        step();
        chk_reset_vals("rst");
        s_rst = 1'b0;

        // Single request from requester 2
        req_data[2*DW +: DW] = 8'hA5;
        req_vld = 4'b0100;
        step();
        chk("single_vld", br_vld, 1);
        chk("single_din", br_din, 10'h2A5);
        chk("single_rdy", req_rdy, 4'b0100);
        chk("single_cnt", xfer_cnt, 1);
        chk("single_gid", grant_id, 2);
        step();
        chk("single_vld_drop", br_vld, 0);
        chk("single_din_hold", br_din, 10'h2A5);
        wait_idle(20);

        // Round robin with all requesters held
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(8'hC0 + i);
        auto_clr = 1'b0;
        req_vld  = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            wait_vld(20, k);
            chk("rr_gid", grant_id, exp_rr[n]);
            chk("rr_din", br_din, 32'((exp_rr[n] << 8) | (32'hC0 + exp_rr[n])));
            step();
        end
        req_vld  = '0;
        auto_clr = 1'b1;
        chk("rr_cnt", xfer_cnt, 8);
        wait_idle(20);

        // Priority skip around the round-robin pointer
        req_vld = 4'b0010;
        wait_vld(10, k);
        chk("skip_first", grant_id, 1);
        step();
        wait_idle(20);
        req_vld = 4'b0011;
        wait_vld(10, k);
        chk("skip_lo", grant_id, 0);
        step();
        wait_idle(20);
        req_vld = 4'b0011;
        wait_vld(10, k);
        chk("skip_hi", grant_id, 1);
        req_vld = '0;
        step();
        wait_idle(20);

        // Bridge busy while idle: no grant until it drops
        force_act = 1'b1;
        req_vld   = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("held_vld", br_vld, 0);
            chk("held_rdy", req_rdy, 0);
            chk("held_busy", busy, 0);
        end
        force_act = 1'b0;
        step();
        chk("release_vld", br_vld, 1);
        chk("release_gid", grant_id, 0);
        chk("release_rdy", req_rdy, 4'b0001);
        wait_idle(20);

        // Watchdog with a bridge that never drops active
        stuck   = 1'b1;
        req_vld = 4'b0100;
        wait_vld(10, k);
        chk("wd_gid", grant_id, 2);
        for (int n = 1; n <= 17; n++) step();
        chk("wd_k17", timeout_err, 0);
        step();
        chk("wd_k18", timeout_err, 0);
        timeout_clr = 1'b1;
        step();
        chk("wd_set_wins", timeout_err, 1);
        timeout_clr = 1'b0;
        step();
        chk("wd_hold", timeout_err, 1);
        chk("wd_busy", busy, 1);
        stuck = 1'b0;
        wait_idle(20);
        chk("wd_sticky", timeout_err, 1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        chk("wd_clr", timeout_err, 0);

        // Reset in the middle of a transfer
        req_vld = 4'b0001;
        wait_vld(10, k);
        chk("mid_gid", grant_id, 0);
        step();
        step();
        step();
        chk("mid_busy", busy, 1);
        chk("mid_active", br_active, 1);
        req_vld = 4'b0011;
        s_rst   = 1'b1;
        step();
        s_rst = 1'b0;
        chk_reset_vals("mid_rst");
        k = 4;
        while (!br_vld && k < 20) begin
            step();
            k++;
        end
        chk("mid_regrant_cyc", k, 7);
        chk("mid_regrant_gid", grant_id, 0);
        req_vld = '0;
        step();
        wait_idle(20);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
